gpio_in_cond: RTL and testbench

- Input-conditioning and interrupt stage that sits directly upstream of the GPIO input port register.
- Takes raw asynchronous pad inputs and passes each through a 2-FF synchronizer and a tick-sampled debouncer.
- Produces a clean parallel bus (gpio_clean_o) that feeds the GPIO input port.
- Detects per-bit selectable edges into a pending register and drives one level interrupt. A small Wishbone slave register file exposes mask, edge select and pending.

---
 rtl/gpio_pkg.sv | 17 +
 rtl/gpio_in_cond_if.sv | 26 ++
 rtl/gpio_debounce_bit.sv | 47 ++++
 rtl/gpio_in_cond.sv | 121 ++++++++++++
 tb/tb_gpio_in_cond.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input-conditioning block: default width,
// debounce counter width and the Wishbone register map.
package gpio_pkg;

  localparam int GPIO_WIDTH = 16;

  // Debounce counter width; covers DEB up to 15.
  localparam int GPIO_CNT_W = 4;

  typedef enum logic [1:0] {
    GPIO_ADR_IN   = 2'd0,
    GPIO_ADR_MASK = 2'd1,
    GPIO_ADR_EDGE = 2'd2,
    GPIO_ADR_PEND = 2'd3
  } gpio_adr_e;

endpackage

// File: rtl/gpio_in_cond_if.sv
// Wishbone-style register bus between a master and the GPIO input-conditioning
// slave.
interface gpio_in_cond_if
  import gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH
);

  logic             stb_i;
  logic             we_i;
  logic [1:0]       adr_i;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] data_o;
  logic             ack_o;

  modport master (
    output stb_i, we_i, adr_i, data_i,
    input  data_o, ack_o
  );

  modport slave (
    input  stb_i, we_i, adr_i, data_i,
    output data_o, ack_o
  );

endinterface

// File: rtl/gpio_debounce_bit.sv
// One GPIO bit: 2-FF synchronizer followed by a tick-sampled debouncer that
// only moves the clean output after DEB consecutive differing samples.
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int DEB = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic pad_i,
  output logic clean_o
);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_clean;
  logic [GPIO_CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer stages.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_clean <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= pad_i;
      r_sync2 <= r_sync1;
      if (tick_i) begin
        if (r_sync2 == r_clean) begin
          r_cnt <= '0;
        end else if (r_cnt == GPIO_CNT_W'(DEB - 1)) begin
          // Enough consecutive disagreeing samples: accept the new level.
          r_clean <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + GPIO_CNT_W'(1);
        end
      end
    end
  end

  assign clean_o = r_clean;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: per-bit synchronize/debounce, selectable edge
// detection into a pending register, level interrupt and a small register file.
module gpio_in_cond
  import gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH,
  parameter int DIV   = 1000,
  parameter int DEB   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  gpio_in_cond_if.slave      wb,
  input  logic [WIDTH-1:0]   gpio_i,
  output logic [WIDTH-1:0]   gpio_clean_o,
  output logic               irq_o
);

  localparam int PW = $clog2(DIV);

  logic [PW-1:0]    r_presc;
  logic             w_tick;
  logic [WIDTH-1:0] w_clean;
  logic [WIDTH-1:0] r_clean_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge_sel;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] r_data;
  logic             r_ack;
  logic             r_irq;

  logic             w_xfer;
  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_rdata;

  // Debounce sample tick, one cycle wide every DIV cycles.
  assign w_tick = (r_presc == PW'(DIV - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    gpio_debounce_bit #(
      .DEB (DEB)
    ) u_deb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .tick_i  (w_tick),
      .pad_i   (gpio_i[b]),
      .clean_o (w_clean[b])
    );
  end

  // A new transfer is accepted only when no ack is outstanding.
  assign w_xfer = wb.stb_i & ~r_ack;
  assign w_wr   = w_xfer & wb.we_i;
  assign w_rd   = w_xfer & ~wb.we_i;

  assign w_rise = w_clean & ~r_clean_prev;
  assign w_fall = ~w_clean & r_clean_prev;
  assign w_set  = (w_rise & r_edge_sel) | (w_fall & ~r_edge_sel);
  assign w_clr  = (w_wr && (wb.adr_i == GPIO_ADR_PEND)) ? wb.data_i : '0;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_rdata = '0;
    case (gpio_adr_e'(wb.adr_i))
      GPIO_ADR_IN:   w_rdata = w_clean;
      GPIO_ADR_MASK: w_rdata = r_mask;
      GPIO_ADR_EDGE: w_rdata = r_edge_sel;
      GPIO_ADR_PEND: w_rdata = r_pending;
      default:       w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_clean_prev <= '0;
      r_mask       <= '0;
      r_edge_sel   <= '0;
      r_pending    <= '0;
      r_data       <= '0;
      r_ack        <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_clean_prev <= w_clean;
      r_ack        <= w_xfer;
      r_irq        <= |(r_pending & r_mask);
      // Set is applied after the clear so a same-cycle edge wins.
      r_pending    <= (r_pending & ~w_clr) | w_set;
      if (w_rd) begin
        r_data <= w_rdata;
      end
      if (w_wr) begin
        case (gpio_adr_e'(wb.adr_i))
          GPIO_ADR_MASK: r_mask     <= wb.data_i;
          GPIO_ADR_EDGE: r_edge_sel <= wb.data_i;
          default:       ;
        endcase
      end
    end
  end

  assign wb.ack_o     = r_ack;
  assign wb.data_o    = r_data;
  assign gpio_clean_o = w_clean;
  assign irq_o        = r_irq;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Self-checking bench for gpio_in_cond: behavioural reference model plus a
// scoreboard of expected bus responses, directed scenarios and random traffic.
module tb_gpio_in_cond;
  import gpio_pkg::*;

  localparam int W   = 16;
  localparam int DIV = 4;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic [W-1:0] gpio_i = '0;
  logic [W-1:0] gpio_clean_o;
  logic         irq_o;

  gpio_in_cond_if #(.WIDTH(W)) bus ();

  gpio_in_cond #(
    .WIDTH (W),
    .DIV   (DIV),
    .DEB   (DEB)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .wb           (bus),
    .gpio_i       (gpio_i),
    .gpio_clean_o (gpio_clean_o),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit           is_read;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];

  // Reference model: state after each rising edge, derived from the block's
  // behaviour (2-cycle delayed pads, debounce by counting differing ticks).
  logic [W-1:0] m_clean, m_prev, m_mask, m_edge, m_pend;
  logic         m_ack, m_irq;
  int           m_presc;
  int           m_run [W];
  logic [W-1:0] m_hist [$];

  initial forever begin
    logic [W-1:0] seen, qual, clr, rd;
    logic         xfer, tick;
    exp_t         e;
    @(posedge clk);
    if (rst_i) begin
      m_clean = '0; m_prev = '0; m_mask = '0; m_edge = '0; m_pend = '0;
      m_ack = 1'b0; m_irq = 1'b0; m_presc = 0;
      for (int b = 0; b < W; b++) m_run[b] = 0;
      m_hist.delete();
      m_hist.push_back('0);
      m_hist.push_back('0);
    end else begin
      seen = m_hist.pop_front();
      m_hist.push_back(gpio_i);
      xfer = bus.stb_i && !m_ack;
      clr  = '0;
      qual = (m_clean & ~m_prev & m_edge) | (~m_clean & m_prev & ~m_edge);
      m_irq = |(m_pend & m_mask);
      if (xfer) begin
        if (bus.we_i) begin
          case (bus.adr_i)
            2'd1: m_mask = bus.data_i;
            2'd2: m_edge = bus.data_i;
            2'd3: clr = bus.data_i;
            default: ;
          endcase
          e.is_read = 1'b0;
          e.data    = '0;
        end else begin
          case (bus.adr_i)
            2'd0: rd = m_clean;
            2'd1: rd = m_mask;
            2'd2: rd = m_edge;
            default: rd = m_pend;
          endcase
          e.is_read = 1'b1;
          e.data    = rd;
        end
        sb.push_back(e);
      end
      m_pend = (m_pend & ~clr) | qual;
      m_ack  = xfer;
      m_prev = m_clean;
      tick   = (m_presc == DIV - 1);
      m_presc = tick ? 0 : m_presc + 1;
      if (tick) begin
        for (int b = 0; b < W; b++) begin
          if (seen[b] == m_clean[b]) begin
            m_run[b] = 0;
          end else begin
            m_run[b]++;
            if (m_run[b] == DEB) begin
              m_clean[b] = seen[b];
              m_run[b] = 0;
            end
          end
        end
      end
    end
  end

  // Monitor: compare outputs each cycle and pop the scoreboard on every ack.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (chk_en) begin
      check("ack_o", bus.ack_o, m_ack);
      check("irq_o", irq_o, m_irq);
      check("gpio_clean_o", gpio_clean_o, m_clean);
      if (bus.ack_o) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack with no request outstanding at %0t", $time);
        end else begin
          e = sb.pop_front();
          if (e.is_read) check("read_data", bus.data_o, e.data);
        end
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [W-1:0] d,
                         output logic [W-1:0] q);
    bus.stb_i  = 1'b1;
    bus.we_i   = we;
    bus.adr_i  = adr;
    bus.data_i = d;
    q = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o) begin
        q = bus.data_o;
        break;
      end
      if (i == 3) begin
        n_checks++;
        n_fail++;
        $display("FAIL wb_ack_timeout: got no ack expected ack within 4 cycles (adr %0d)", adr);
      end
    end
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [W-1:0] d);
    logic [W-1:0] q;
    wb_xfer(1'b1, adr, d, q);
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [W-1:0] q);
    wb_xfer(1'b0, adr, '0, q);
  endtask

  task automatic wait_clean(input int b, input logic v, input string name);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (gpio_clean_o[b] == v) return;
    end
    check(name, gpio_clean_o[b], v);
  endtask

  task automatic do_reset(input logic [W-1:0] pads);
    rst_i  = 1'b1;
    gpio_i = pads;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    logic [W-1:0] q;
    logic [3:0]   seq;
    bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.adr_i = '0; bus.data_i = '0;

    // Reset with all pads high.
    do_reset('1);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_clean", gpio_clean_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_ack", bus.ack_o, 0);
    check("rst_data", bus.data_o, 0);
    for (int i = 0; i < 200 && gpio_clean_o !== '1; i++) @(posedge clk);
    #1;
    check("rst_clean_settles_high", gpio_clean_o, 16'hFFFF);
    wb_read(2'd3, q);
    check("rst_no_pending_on_rise", q, 0);

    // Glitch shorter than DEB ticks never reaches the clean bus.
    do_reset('0);
    repeat (10) @(posedge clk);
    #1;
    gpio_i[0] = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    gpio_i[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("glitch_clean0", gpio_clean_o[0], 0);
    wb_read(2'd3, q);
    check("glitch_pending", q, 0);

    // Rising edge on bit 0, unmasked, raises irq; W1C clears it.
    wb_write(2'd1, 16'h0001);
    wb_write(2'd2, 16'h0001);
    gpio_i[0] = 1'b1;
    for (int i = 0; i < 200 && irq_o !== 1'b1; i++) @(posedge clk);
    #1;
    check("edge_irq_high", irq_o, 1);
    wb_read(2'd3, q);
    check("edge_pending", q, 16'h0001);
    wb_write(2'd3, 16'h0001);
    @(posedge clk); #1;
    check("w1c_irq_low", irq_o, 0);
    wb_read(2'd3, q);
    check("w1c_pending", q, 0);

    // Masked falling edge on bit 3 still latches pending.
    wb_write(2'd1, 16'h0000);
    gpio_i[3] = 1'b1;
    wait_clean(3, 1'b1, "bit3_rise");
    gpio_i[3] = 1'b0;
    wait_clean(3, 1'b0, "bit3_fall");
    repeat (2) @(posedge clk);
    #1;
    wb_read(2'd3, q);
    check("masked_pending", q, 16'h0008);
    check("masked_irq_low", irq_o, 0);
    wb_write(2'd1, 16'h0008);
    @(posedge clk); #1;
    check("unmask_irq_high", irq_o, 1);

    // Set and W1C clear of bit 0 in the same cycle: set wins.
    gpio_i[0] = 1'b0;
    wait_clean(0, 1'b0, "bit0_fall");
    wb_write(2'd3, 16'hFFFF);
    gpio_i[0] = 1'b1;
    wait_clean(0, 1'b1, "bit0_rise");
    wb_write(2'd3, 16'h0001);
    wb_read(2'd3, q);
    check("collision_pending0", q[0], 1);

    // Held strobe acks every other cycle with the addressed register.
    wb_write(2'd1, 16'hA5A5);
    @(posedge clk); #1;
    bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = 2'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seq[i] = bus.ack_o;
      if (bus.ack_o) check("held_stb_data", bus.data_o, 16'hA5A5);
    end
    bus.stb_i = 1'b0;
    check("held_stb_ack_seq", seq, 4'b1010);
    @(posedge clk); #1;

    // Reset mid-write aborts the transfer.
    bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.adr_i = 2'd1; bus.data_i = 16'h1234;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    bus.stb_i = 1'b0; bus.we_i = 1'b0;
    @(negedge clk);
    check("abort_ack_low", bus.ack_o, 0);
    @(posedge clk); #1;
    wb_read(2'd1, q);
    check("abort_mask_unchanged", q, 0);

    // Random pad activity and register traffic against the model.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) == 0) gpio_i = gpio_i ^ W'($urandom & $urandom);
      repeat ($urandom_range(0, 12)) @(posedge clk);
      #1;
      if ($urandom_range(0, 1) == 0)
        wb_read(2'($urandom_range(0, 3)), q);
      else
        wb_write(2'($urandom_range(0, 3)), W'($urandom));
    end

    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
